prirv32_fetch_queue: RTL

Instruction-fetch front end for the priRV32 core, sitting directly upstream of the instruction decoder. It generates the program counter, issues in-order word requests to instruction memory under a credit limit, and buffers returned instructions with their PCs in a small FIFO. The decoder drains the FIFO through a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes the FIFO and discards stale in-flight responses.

---
 rtl/prirv32_fetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prirv32_fetch_queue.sv
// priRV32 instruction-fetch front end: PC generation, credit-limited imem requests,
// and a small {instr, pc} FIFO feeding the decoder, with redirect flush and stale-response drop.
module prirv32_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, discard, discard_nx, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [FIFO_DEPTH];

  logic          grant, push, pop;
  logic [CW-1:0] out_after_rsp;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc;

  assign redirect_pc   = redirect_pc_i & ~32'h3;
  assign out_after_rsp = outstanding - CW'(imem_rvalid_i);

  // Every granted request already owns a FIFO slot, so a response can always be pushed.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = (state == RUN) && !redirect_i && (credit_used < DEPTH_W);
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  assign push = imem_rvalid_i && !redirect_i && (discard == '0);
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? mem[rd_ptr].instr : 32'h0;
  assign instr_pc_o    = instr_valid_o ? mem[rd_ptr].pc    : 32'h0;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    discard_nx = discard;
    if (redirect_i)
      discard_nx = out_after_rsp;
    else if ((discard != '0) && imem_rvalid_i)
      discard_nx = discard - ONE;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (redirect_i && (out_after_rsp != '0)) state_nx = DRAIN;
      DRAIN:   if (!redirect_i && (discard_nx == '0)) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;

      case ({grant, imem_rvalid_i})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: outstanding <= outstanding;
      endcase

      if (redirect_i) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + ONE;
          2'b01:   count <= count - ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{instr: imem_rdata_i, pc: resp_pc};
  end

endmodule
